serpent_xts_key_ctrl: RTL and testbench
=======================================

Name: serpent_xts_key_ctrl

Overview:
Sequences the shared Serpent key-schedule engine for XTS operation. On one load command it expands the tweak key (key2), then the data key (key1), and captures each 33-entry subkey stream into its own bank. It then serves subkeys to the data-cipher core and the tweak-cipher core through one shared, arbitrated read port. It sits between the key-input registers, the key-schedule engine and the two cipher cores.

Parameters:
KEY_W, 256, width of each user key
SUBKEY_W, 128, width of one round subkey
NUM_SUBKEYS, 33, subkeys per key (rounds + 1)
ADDR_W, 6, subkey index width

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_load  in  1  pulse; start expansion of i_key1/i_key2
i_key1  in  KEY_W  data key, sampled only in the cycle i_load is accepted
i_key2  in  KEY_W  tweak key, sampled only in the cycle i_load is accepted
o_busy  out  1  expansion in progress
o_ready  out  1  both banks valid
o_key_err  out  1  sticky; schedule ended with wrong subkey count
o_ks_begin  out  1  one-cycle start pulse to key-schedule engine
o_ks_key  out  KEY_W  key presented to engine, held stable while busy
i_ks_subkey  in  SUBKEY_W  subkey from engine
i_ks_address  in  ADDR_W  subkey index from engine
i_ks_we  in  1  i_ks_subkey/i_ks_address valid this cycle
i_ks_done  in  1  engine finished current key
i_rd_req  in  2  bit0 data core (bank0/key1), bit1 tweak core (bank1/key2)
i_rd_addr0  in  ADDR_W  index requested by requester 0
i_rd_addr1  in  ADDR_W  index requested by requester 1
o_rd_gnt  out  2  one-hot grant, combinational, same cycle as request
o_rd_data  out  SUBKEY_W  subkey, one cycle after grant
o_rd_valid  out  1  o_rd_data valid
o_rd_id  out  1  requester that owns o_rd_data

Behaviour:
- Reset values: o_busy=0, o_ready=0, o_key_err=0, o_ks_begin=0, o_ks_key=0, o_rd_gnt=0, o_rd_data=0, o_rd_valid=0, o_rd_id=0, priority pointer=0, write counter=0, FSM=IDLE. Bank contents need not be reset.
- FSM states and transitions:
  - IDLE: i_load latches both keys, clears o_ready, clears o_key_err, then goes to START_K2.
  - START_K2: o_ks_begin=1 for exactly one cycle, o_ks_key=key2, counter=0, then goes to RUN_K2.
  - RUN_K2: each i_ks_we writes bank1[i_ks_address] and increments the counter. i_ks_done goes to START_K1.
  - START_K1: o_ks_begin=1 for exactly one cycle, o_ks_key=key1, counter=0, then goes to RUN_K1.
  - RUN_K1: i_ks_we writes bank0. i_ks_done goes to IDLE and sets o_ready=1.
- o_busy=1 in every state except IDLE.
- i_load while busy is ignored. i_load while ready restarts expansion and drops o_ready in the next cycle.
- i_ks_we with i_ks_address>=NUM_SUBKEYS: no write, counter still increments.
- i_ks_we and i_ks_done in the same cycle: the write is performed and counted before the count check.
- At each i_ks_done, if the count including that cycle is not NUM_SUBKEYS, o_key_err is set. The sequence continues regardless.
- i_ks_we or i_ks_done seen in IDLE, START_K2 or START_K1: ignored.
- Read arbitration:
  - No grant while o_ready=0; requests stay pending.
  - One requester active: it is granted.
  - Both active: grant goes to the priority pointer. After any grant, the pointer moves to the other requester.
- Read timing: a grant in cycle N gives o_rd_valid=1, o_rd_id and o_rd_data in cycle N+1. A read address >=NUM_SUBKEYS returns zero data.
- A requester holds req and addr stable until it is granted. One grant per cycle, so back-to-back reads give full throughput.
- Reset asserted mid-operation returns everything to reset values immediately. Bank contents are then treated as invalid.

Decomposition:
- Shared package serpent_pkg holds:
  - KEY_W, SUBKEY_W, NUM_SUBKEYS, ADDR_W
  - the FSM state encoding (IDLE, START_K2, RUN_K2, START_K1, RUN_K1)
  - the XTS bank index constants (BANK_DATA=0, BANK_TWEAK=1)
- One sub-module, subkey_bank: NUM_SUBKEYS x SUBKEY_W storage with one write port and one registered read port. It is instantiated twice, with the read mux selected by the registered grant id.

Test Plan:
- Happy-path load:
  - Stimulus: i_load with key1=0x00..01, key2=0xFF..FE. The engine model emits 33 writes (addr 0..32, data={addr,addr,addr,addr}), then done, for each key.
  - Response: o_ks_begin pulses twice, key2 first. o_ready rises the cycle after the second done. o_key_err=0.
- Readback:
  - Stimulus: requester 0 reads addr 5, then requester 1 reads addr 32.
  - Response: each returns data one cycle after its grant, with o_rd_id 0 then 1 and the expected bank contents.
- Contention:
  - Stimulus: both requesters hold req for 4 cycles.
  - Response: grants go 0,1,0,1 starting from pointer=0. Exactly one o_rd_valid per cycle.
- Gating:
  - Stimulus: requests asserted during expansion, plus a second i_load mid-RUN_K2.
  - Response: no grants until o_ready. The second load is ignored, so only 2 begin pulses appear in total.
- Count error:
  - Stimulus: the engine model emits 32 writes, then done, for key2.
  - Response: o_key_err=1, the sequence still completes, o_ready=1.
- Reset mid-RUN_K1:
  - Stimulus: i_rstn low for 1 cycle during RUN_K1.
  - Response: all outputs return to reset values at once and stay in IDLE until a new i_load.

Source files
------------

// File: rtl/serpent_pkg.sv
// Shared Serpent/XTS key-controller constants, bank indices and FSM encoding.
// Also holds the subkey-index range check used by the write and read paths.
package serpent_pkg;

  localparam int KEY_W       = 256;
  localparam int SUBKEY_W    = 128;
  localparam int NUM_SUBKEYS = 33;
  localparam int ADDR_W      = 6;
  localparam int CNT_W       = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] NUM_SK_A = ADDR_W'(NUM_SUBKEYS);
  localparam logic [CNT_W-1:0]  NUM_SK_C = CNT_W'(NUM_SUBKEYS);

  localparam int BANK_DATA  = 0;
  localparam int BANK_TWEAK = 1;

  typedef enum logic [2:0] {
    IDLE,
    START_K2,
    RUN_K2,
    START_K1,
    RUN_K1
  } ks_state_t;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return a < NUM_SK_A;
  endfunction

endpackage

// File: rtl/serpent_xts_key_ctrl_if.sv
// Shared subkey read port: cipher cores request (master), key controller grants (slave).
// Grant is same-cycle combinational; data/valid/id follow one cycle later.
interface serpent_xts_key_ctrl_if;
  import serpent_pkg::*;

  logic [1:0]          rd_req;
  logic [ADDR_W-1:0]   rd_addr0;
  logic [ADDR_W-1:0]   rd_addr1;
  logic [1:0]          rd_gnt;
  logic [SUBKEY_W-1:0] rd_data;
  logic                rd_valid;
  logic                rd_id;

  modport master (
    output rd_req, rd_addr0, rd_addr1,
    input  rd_gnt, rd_data, rd_valid, rd_id
  );

  modport slave (
    input  rd_req, rd_addr0, rd_addr1,
    output rd_gnt, rd_data, rd_valid, rd_id
  );

endinterface

// File: rtl/subkey_bank.sv
// NUM_SUBKEYS x SUBKEY_W subkey store, one write port and one registered read port.
// Read data lands one cycle after i_re; out-of-range indices read as zero.
module subkey_bank import serpent_pkg::*; (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_waddr,
  input  logic [SUBKEY_W-1:0] i_wdata,
  input  logic                i_re,
  input  logic [ADDR_W-1:0]   i_raddr,
  output logic [SUBKEY_W-1:0] o_rdata
);

  logic [SUBKEY_W-1:0] r_mem [NUM_SUBKEYS];
  logic [SUBKEY_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we && addr_ok(i_waddr)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= addr_ok(i_raddr) ? r_mem[i_raddr] : '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/serpent_xts_key_ctrl.sv
// Runs the shared key schedule for key2 then key1 into two subkey banks, then serves
// both cipher cores via one round-robin read port (grant same cycle, data next cycle).
module serpent_xts_key_ctrl import serpent_pkg::*; (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_load,
  input  logic [KEY_W-1:0]      i_key1,
  input  logic [KEY_W-1:0]      i_key2,
  output logic                  o_busy,
  output logic                  o_ready,
  output logic                  o_key_err,
  output logic                  o_ks_begin,
  output logic [KEY_W-1:0]      o_ks_key,
  input  logic [SUBKEY_W-1:0]   i_ks_subkey,
  input  logic [ADDR_W-1:0]     i_ks_address,
  input  logic                  i_ks_we,
  input  logic                  i_ks_done,
  serpent_xts_key_ctrl_if.slave io_rd
);

  ks_state_t           r_state;
  logic [KEY_W-1:0]    r_key1;
  logic [KEY_W-1:0]    r_ks_key;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_ready;
  logic                r_err;
  logic                r_ks_begin;
  logic                r_ptr;
  logic                r_rd_valid;
  logic                r_rd_id;

  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_cnt_bad;
  logic                w_we_data;
  logic                w_we_tweak;
  logic [1:0]          w_gnt;
  logic [SUBKEY_W-1:0] w_rdata_data;
  logic [SUBKEY_W-1:0] w_rdata_tweak;

  // A write arriving with done is counted before the final count is judged.
  assign w_cnt_nxt  = r_cnt + CNT_W'(i_ks_we);
  assign w_cnt_bad  = (w_cnt_nxt != NUM_SK_C);
  assign w_we_tweak = (r_state == RUN_K2) && i_ks_we;
  assign w_we_data  = (r_state == RUN_K1) && i_ks_we;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= IDLE;
      r_key1     <= '0;
      r_ks_key   <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_ks_begin <= 1'b0;
    end else begin
      r_ks_begin <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_load) begin
            r_key1     <= i_key1;
            r_ks_key   <= i_key2;
            r_ks_begin <= 1'b1;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= START_K2;
          end
        end
        START_K2: begin
          r_cnt   <= '0;
          r_state <= RUN_K2;
        end
        RUN_K2: begin
          r_cnt <= w_cnt_nxt;
          if (i_ks_done) begin
            if (w_cnt_bad) r_err <= 1'b1;
            r_ks_key   <= r_key1;
            r_ks_begin <= 1'b1;
            r_state    <= START_K1;
          end
        end
        START_K1: begin
          r_cnt   <= '0;
          r_state <= RUN_K1;
        end
        RUN_K1: begin
          r_cnt <= w_cnt_nxt;
          if (i_ks_done) begin
            if (w_cnt_bad) r_err <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_gnt = 2'b00;
    if (r_ready) begin
      if (&io_rd.rd_req) w_gnt[r_ptr] = 1'b1;
      else               w_gnt = io_rd.rd_req;
    end
  end

  // The pointer always lands on the requester that was not just served.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ptr      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_id    <= 1'b0;
    end else begin
      r_rd_valid <= |w_gnt;
      if (|w_gnt) begin
        r_rd_id <= w_gnt[BANK_TWEAK];
        r_ptr   <= w_gnt[BANK_DATA];
      end
    end
  end

  subkey_bank u_bank_data (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_we    (w_we_data),
    .i_waddr (i_ks_address),
    .i_wdata (i_ks_subkey),
    .i_re    (w_gnt[BANK_DATA]),
    .i_raddr (io_rd.rd_addr0),
    .o_rdata (w_rdata_data)
  );

  subkey_bank u_bank_tweak (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_we    (w_we_tweak),
    .i_waddr (i_ks_address),
    .i_wdata (i_ks_subkey),
    .i_re    (w_gnt[BANK_TWEAK]),
    .i_raddr (io_rd.rd_addr1),
    .o_rdata (w_rdata_tweak)
  );

  assign o_busy         = r_busy;
  assign o_ready        = r_ready;
  assign o_key_err      = r_err;
  assign o_ks_begin     = r_ks_begin;
  assign o_ks_key       = r_ks_key;
  assign io_rd.rd_gnt   = w_gnt;
  assign io_rd.rd_valid = r_rd_valid;
  assign io_rd.rd_id    = r_rd_id;
  assign io_rd.rd_data  = r_rd_id ? w_rdata_tweak : w_rdata_data;

endmodule

// File: tb/tb_serpent_xts_key_ctrl.sv
// Directed bench for serpent_xts_key_ctrl: engine model, expected-bank model and
// per-scenario tasks with inline comparisons.
module tb_serpent_xts_key_ctrl;
  import serpent_pkg::*;

  localparam logic [KEY_W-1:0] K1  = 256'h1;
  localparam logic [KEY_W-1:0] K2  = {{255{1'b1}}, 1'b0};
  localparam logic [KEY_W-1:0] K1B = {64'h1111_2222_3333_4444, 192'h0};
  localparam logic [KEY_W-1:0] K2B = {192'h0, 64'h5555_6666_7777_8888};
  localparam logic [31:0] T_DATA   = 32'hDA7A_0000;
  localparam logic [31:0] T_TWEAK  = 32'h7EE0_0000;
  localparam logic [31:0] T_DATA2  = 32'hDA7B_0000;
  localparam logic [31:0] T_TWEAK2 = 32'h7EE1_0000;

  logic                clk = 1'b0;
  logic                rstn;
  logic                load;
  logic [KEY_W-1:0]    key1;
  logic [KEY_W-1:0]    key2;
  logic                busy;
  logic                ready;
  logic                kerr;
  logic                ks_begin;
  logic [KEY_W-1:0]    ks_key;
  logic [SUBKEY_W-1:0] ks_sub;
  logic [ADDR_W-1:0]   ks_addr;
  logic                ks_we;
  logic                ks_done;

  int checks = 0;
  int errors = 0;
  int begin_cnt = 0;
  logic [KEY_W-1:0]    bkeys [$];
  logic [SUBKEY_W-1:0] m_bank [2][NUM_SUBKEYS];

  serpent_xts_key_ctrl_if rd_if ();

  serpent_xts_key_ctrl dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_load       (load),
    .i_key1       (key1),
    .i_key2       (key2),
    .o_busy       (busy),
    .o_ready      (ready),
    .o_key_err    (kerr),
    .o_ks_begin   (ks_begin),
    .o_ks_key     (ks_key),
    .i_ks_subkey  (ks_sub),
    .i_ks_address (ks_addr),
    .i_ks_we      (ks_we),
    .i_ks_done    (ks_done),
    .io_rd        (rd_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ks_begin === 1'b1) begin
      begin_cnt++;
      bkeys.push_back(ks_key);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [KEY_W-1:0] k1, input logic [KEY_W-1:0] k2);
    key1 = k1;
    key2 = k2;
    load = 1'b1;
    tick();
    load = 1'b0;
    key1 = '0;
    key2 = '0;
  endtask

  // Waits for a begin pulse, then plays one key schedule into the DUT.
  task automatic engine_key(input int nwr, input int bank, input logic [31:0] tag,
                            input bit done_last, input int bad_at, input int load_at,
                            input bit chk_gate);
    bit found = 1'b0;
    logic [ADDR_W-1:0] a;
    for (int w = 0; w < 20 && !found; w++) begin
      @(negedge clk);
      if (ks_begin === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL begin_wait: o_ks_begin not seen within 20 cycles");
    end
    tick();
    for (int i = 0; i < nwr; i++) begin
      a       = (i == bad_at) ? ADDR_W'(40) : ADDR_W'(i);
      ks_we   = 1'b1;
      ks_addr = a;
      ks_sub  = {4{tag | 32'(i)}};
      ks_done = done_last && (i == nwr - 1);
      load    = (i == load_at);
      if (a < NUM_SK_A) m_bank[bank][a] = ks_sub;
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || (chk_gate && rd_if.rd_gnt !== 2'b00)) begin
        errors++;
        $display("FAIL expand_gate: write %0d ready=%b gnt=%b, want ready=0 gnt=00", i, ready, rd_if.rd_gnt);
      end
      tick();
    end
    ks_we   = 1'b0;
    load    = 1'b0;
    ks_done = 1'b0;
    if (!done_last) begin
      ks_done = 1'b1;
      tick();
      ks_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, ready, kerr, ks_begin} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/ready/err/begin=%b want 0000", {busy, ready, kerr, ks_begin});
    end
    checks++;
    if (ks_key !== '0) begin
      errors++;
      $display("FAIL reset_ks_key: got %h want 0", ks_key);
    end
    checks++;
    if ({rd_if.rd_gnt, rd_if.rd_valid, rd_if.rd_id} !== 4'b0000 || rd_if.rd_data !== '0) begin
      errors++;
      $display("FAIL reset_rd: gnt=%b valid=%b id=%b data=%h want all 0", rd_if.rd_gnt, rd_if.rd_valid, rd_if.rd_id, rd_if.rd_data);
    end
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_load();
    int c0 = begin_cnt;
    int q0 = bkeys.size();
    tick();
    do_load(K1, K2);
    engine_key(33, BANK_TWEAK, T_TWEAK, 1'b0, -1, -1, 1'b0);
    engine_key(33, BANK_DATA, T_DATA, 1'b0, -1, -1, 1'b0);
    @(negedge clk);
    checks++;
    if ({ready, busy, kerr} !== 3'b100) begin
      errors++;
      $display("FAIL load_done: ready/busy/err=%b want 100", {ready, busy, kerr});
    end
    checks++;
    if (begin_cnt - c0 != 2) begin
      errors++;
      $display("FAIL load_begins: got %0d pulses want 2", begin_cnt - c0);
    end else begin
      checks++;
      if (bkeys[q0] !== K2 || bkeys[q0+1] !== K1) begin
        errors++;
        $display("FAIL load_key_order: first=%h second=%h want key2 then key1", bkeys[q0], bkeys[q0+1]);
      end
    end
  endtask

  task automatic test_readback();
    logic [1:0] rq [3] = '{2'b01, 2'b10, 2'b10};
    logic [ADDR_W-1:0] ad [3] = '{6'd5, 6'd32, 6'd40};
    logic [SUBKEY_W-1:0] exp;
    for (int k = 0; k < 3; k++) begin
      tick();
      rd_if.rd_req   = rq[k];
      rd_if.rd_addr0 = ad[k];
      rd_if.rd_addr1 = ad[k];
      exp = (ad[k] >= NUM_SK_A) ? '0 : m_bank[rq[k][1]][ad[k]];
      @(negedge clk);
      checks++;
      if (rd_if.rd_gnt !== rq[k]) begin
        errors++;
        $display("FAIL readback_gnt%0d: got %b want %b", k, rd_if.rd_gnt, rq[k]);
      end
      tick();
      rd_if.rd_req = 2'b00;
      @(negedge clk);
      checks++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_id !== rq[k][1] || rd_if.rd_data !== exp) begin
        errors++;
        $display("FAIL readback_data%0d: valid=%b id=%b data=%h want 1 %b %h", k, rd_if.rd_valid, rd_if.rd_id, rd_if.rd_data, rq[k][1], exp);
      end
    end
    tick();
    @(negedge clk);
    checks++;
    if (rd_if.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL readback_idle: valid=%b want 0", rd_if.rd_valid);
    end
  endtask

  task automatic test_contention();
    logic [SUBKEY_W-1:0] exp;
    logic [1:0] eg;
    tick();
    rd_if.rd_req   = 2'b11;
    rd_if.rd_addr0 = 6'd1;
    rd_if.rd_addr1 = 6'd2;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) rd_if.rd_req = 2'b00;
      eg = (k == 4) ? 2'b00 : ((k % 2 == 1) ? 2'b10 : 2'b01);
      @(negedge clk);
      checks++;
      if (rd_if.rd_gnt !== eg) begin
        errors++;
        $display("FAIL contention_gnt%0d: got %b want %b", k, rd_if.rd_gnt, eg);
      end
      if (k > 0) begin
        exp = ((k - 1) % 2 == 1) ? m_bank[1][2] : m_bank[0][1];
        checks++;
        if (rd_if.rd_valid !== 1'b1 || rd_if.rd_id !== 1'((k - 1) % 2) || rd_if.rd_data !== exp) begin
          errors++;
          $display("FAIL contention_rd%0d: valid=%b id=%b data=%h want 1 %0d %h", k, rd_if.rd_valid, rd_if.rd_id, rd_if.rd_data, (k - 1) % 2, exp);
        end
      end
      tick();
    end
  endtask

  task automatic test_gating();
    int c0 = begin_cnt;
    do_load(K1B, K2B);
    rd_if.rd_req   = 2'b11;
    rd_if.rd_addr0 = 6'd3;
    rd_if.rd_addr1 = 6'd4;
    engine_key(33, BANK_TWEAK, T_TWEAK2, 1'b0, -1, 10, 1'b1);
    engine_key(33, BANK_DATA, T_DATA2, 1'b0, -1, -1, 1'b1);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || rd_if.rd_gnt !== 2'b01) begin
      errors++;
      $display("FAIL gating_release: ready=%b gnt=%b want 1 01", ready, rd_if.rd_gnt);
    end
    checks++;
    if (begin_cnt - c0 != 2) begin
      errors++;
      $display("FAIL gating_begins: got %0d pulses want 2", begin_cnt - c0);
    end
    tick();
    rd_if.rd_req = 2'b10;
    @(negedge clk);
    checks++;
    if (rd_if.rd_valid !== 1'b1 || rd_if.rd_id !== 1'b0 || rd_if.rd_data !== m_bank[0][3] || rd_if.rd_gnt !== 2'b10) begin
      errors++;
      $display("FAIL gating_rd0: valid=%b id=%b data=%h gnt=%b want 1 0 %h 10", rd_if.rd_valid, rd_if.rd_id, rd_if.rd_data, rd_if.rd_gnt, m_bank[0][3]);
    end
    tick();
    rd_if.rd_req = 2'b00;
    @(negedge clk);
    checks++;
    if (rd_if.rd_valid !== 1'b1 || rd_if.rd_id !== 1'b1 || rd_if.rd_data !== m_bank[1][4]) begin
      errors++;
      $display("FAIL gating_rd1: valid=%b id=%b data=%h want 1 1 %h", rd_if.rd_valid, rd_if.rd_id, rd_if.rd_data, m_bank[1][4]);
    end
  endtask

  task automatic test_count_err();
    tick();
    do_load(K1, K2);
    engine_key(32, BANK_TWEAK, T_TWEAK, 1'b0, -1, -1, 1'b0);
    checks++;
    if (kerr !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL count_err_set: err=%b busy=%b want 1 1", kerr, busy);
    end
    engine_key(33, BANK_DATA, T_DATA, 1'b0, -1, -1, 1'b0);
    @(negedge clk);
    checks++;
    if ({ready, busy, kerr} !== 3'b101) begin
      errors++;
      $display("FAIL count_err_done: ready/busy/err=%b want 101", {ready, busy, kerr});
    end
  endtask

  task automatic test_range_same_cycle();
    tick();
    do_load(K1, K2);
    checks++;
    if (kerr !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reload_clear: err=%b ready=%b want 0 0", kerr, ready);
    end
    engine_key(33, BANK_TWEAK, T_TWEAK, 1'b0, 0, -1, 1'b0);
    engine_key(33, BANK_DATA, T_DATA, 1'b1, -1, -1, 1'b0);
    @(negedge clk);
    checks++;
    if ({ready, busy, kerr} !== 3'b100) begin
      errors++;
      $display("FAIL range_same_cycle: ready/busy/err=%b want 100", {ready, busy, kerr});
    end
  endtask

  task automatic test_reset_mid();
    int c0 = begin_cnt;
    tick();
    do_load(K1, K2);
    engine_key(32, BANK_TWEAK, T_TWEAK, 1'b0, -1, -1, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      ks_we   = 1'b1;
      ks_addr = ADDR_W'(i);
      ks_sub  = '1;
      tick();
    end
    ks_we = 1'b0;
    rd_if.rd_req = 2'b01;
    checks++;
    if (kerr !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: err=%b busy=%b want 1 1", kerr, busy);
    end
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, ready, kerr, ks_begin} !== 4'b0000 || ks_key !== '0) begin
      errors++;
      $display("FAIL reset_mid_flags: busy/ready/err/begin=%b ks_key=%h want 0000 0", {busy, ready, kerr, ks_begin}, ks_key);
    end
    checks++;
    if ({rd_if.rd_gnt, rd_if.rd_valid, rd_if.rd_id} !== 4'b0000 || rd_if.rd_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_rd: gnt=%b valid=%b id=%b data=%h want all 0", rd_if.rd_gnt, rd_if.rd_valid, rd_if.rd_id, rd_if.rd_data);
    end
    tick();
    rstn    = 1'b1;
    ks_we   = 1'b1;
    ks_done = 1'b1;
    ks_addr = 6'd3;
    tick();
    ks_we   = 1'b0;
    ks_done = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({busy, ready, kerr} !== 3'b000 || rd_if.rd_gnt !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_idle: busy/ready/err=%b gnt=%b want 000 00", {busy, ready, kerr}, rd_if.rd_gnt);
    end
    checks++;
    if (begin_cnt - c0 != 2) begin
      errors++;
      $display("FAIL reset_mid_begins: got %0d pulses want 2", begin_cnt - c0);
    end
    rd_if.rd_req = 2'b00;
  endtask

  initial begin
    load           = 1'b0;
    key1           = '0;
    key2           = '0;
    ks_sub         = '0;
    ks_addr        = '0;
    ks_we          = 1'b0;
    ks_done        = 1'b0;
    rd_if.rd_req   = 2'b00;
    rd_if.rd_addr0 = '0;
    rd_if.rd_addr1 = '0;
    test_reset();
    test_load();
    test_readback();
    test_contention();
    test_gating();
    test_count_err();
    test_range_same_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
